// File: rtl/div_seq_nb.sv
// Sequential restoring divider, signed or unsigned per operation, WIDTH-bit quotient and remainder.
// Latency: init edge k -> done_o in cycle k+N+2, N = WIDTH/BITS_PER_CYCLE, fixed for every operand pair.
// Backpressure: none; init_i is ignored while busy_o or done_o is high, and results hold until the next done_o.
// Ports: clk_i/rst_i clock and synchronous active-high reset; init_i/signed_i/divided_i/divisor_i start an op;
//        busy_o/done_o status; dbz_o/quotient_o/remainder_o registered results.
module div_seq_nb #(
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             init_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] divided_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             dbz_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned N  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic             signed_q, quo_neg_q, rem_neg_q, zdiv_q;
  // dvd_q holds the dividend magnitude and is refilled from the bottom with quotient bits.
  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_out_q, rem_out_q;
  logic             dbz_out_q;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] acc_c, rem_c, quo_fix_c, rem_fix_c;
  logic [WIDTH:0]   shifted_c;

  // The magnitude of the most negative value is 2^(WIDTH-1), which fits as WIDTH-bit unsigned.
  assign dvd_mag = (signed_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
  assign dvs_mag = (signed_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: if (init_i) state_d = PREP;
      PREP: begin
        busy_o  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        busy_o = 1'b1;
        if (cnt_q == '0) state_d = FIX;
      end
      FIX: begin
        busy_o  = 1'b1;
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // BITS_PER_CYCLE chained restoring steps. The shifted partial remainder can reach
  // 2^(WIDTH+1)-1 for large unsigned divisors, hence the one-bit-wider compare.
  always_comb begin
    acc_c     = dvd_q;
    rem_c     = rem_q;
    shifted_c = '0;
    for (int b = 0; b < int'(BITS_PER_CYCLE); b++) begin
      shifted_c = {rem_c, acc_c[WIDTH-1]};
      acc_c     = {acc_c[WIDTH-2:0], 1'b0};
      if (shifted_c >= {1'b0, dvs_q}) begin
        rem_c    = WIDTH'(shifted_c - {1'b0, dvs_q});
        acc_c[0] = 1'b1;
      end else begin
        rem_c = shifted_c[WIDTH-1:0];
      end
    end
    // Divide by zero naturally yields rem = |dividend|; only the quotient needs forcing.
    quo_fix_c = zdiv_q ? '1 : (quo_neg_q ? -acc_c : acc_c);
    rem_fix_c = rem_neg_q ? -rem_c : rem_c;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      signed_q  <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      zdiv_q    <= 1'b0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (init_i) begin
            signed_q <= signed_i;
            dvd_q    <= divided_i;
            dvs_q    <= divisor_i;
          end
        end
        PREP: begin
          dvd_q     <= dvd_mag;
          dvs_q     <= dvs_mag;
          quo_neg_q <= signed_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          rem_neg_q <= signed_q & dvd_q[WIDTH-1];
          zdiv_q    <= (dvs_q == '0);
          rem_q     <= '0;
          cnt_q     <= CW'(N - 1);
        end
        CALC: begin
          dvd_q <= acc_c;
          rem_q <= rem_c;
          cnt_q <= cnt_q - CW'(1);
          // Results land on the edge entering FIX so they are valid in the done_o cycle.
          if (cnt_q == '0) begin
            quo_out_q <= quo_fix_c;
            rem_out_q <= rem_fix_c;
            dbz_out_q <= zdiv_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient_o  = quo_out_q;
  assign remainder_o = rem_out_q;
  assign dbz_o       = dbz_out_q;

endmodule

// File: tb/tb_div_seq_nb.sv
module tb_div_seq_nb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init1 = 1'b0, init2 = 1'b0;
  logic        sgn = 1'b0;
  logic [63:0] dvd = '0, dvs = '0;
  logic        busy1, done1, dbz1, busy2, done2, dbz2;
  logic [63:0] q1, r1, q2, r2;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  div_seq_nb #(.WIDTH(64), .BITS_PER_CYCLE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .init_i(init1), .signed_i(sgn),
    .divided_i(dvd), .divisor_i(dvs), .busy_o(busy1), .done_o(done1),
    .dbz_o(dbz1), .quotient_o(q1), .remainder_o(r1));

  div_seq_nb #(.WIDTH(64), .BITS_PER_CYCLE(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .init_i(init2), .signed_i(sgn),
    .divided_i(dvd), .divisor_i(dvs), .busy_o(busy2), .done_o(done2),
    .dbz_o(dbz2), .quotient_o(q2), .remainder_o(r2));

  // One full operation on dut1 (sel=1, done at cycle 66) or dut2 (sel=2, done at cycle 34).
  task automatic do_op(input int sel, input logic sg, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] eq, input logic [63:0] er, input logic ed, input string nm);
    int          lat;
    int          bad_cyc;
    logic        bz, dn, z;
    logic [63:0] q, r;
    lat = (sel == 1) ? 66 : 34;
    bad_cyc = -1;
    @(negedge clk);
    sgn = sg; dvd = a; dvs = b;
    if (sel == 1) init1 = 1'b1; else init2 = 1'b1;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      init1 = 1'b0; init2 = 1'b0;
      bz = (sel == 1) ? busy1 : busy2;
      dn = (sel == 1) ? done1 : done2;
      if ((bz !== 1'b1 || dn !== (c == lat)) && bad_cyc < 0) bad_cyc = c;
    end
    q = (sel == 1) ? q1 : q2;
    r = (sel == 1) ? r1 : r2;
    z = (sel == 1) ? dbz1 : dbz2;
    checks++;
    if (bad_cyc >= 0) begin
      errors++;
      $display("FAIL %s timing: busy/done wrong at cycle %0d, done required at cycle %0d", nm, bad_cyc, lat);
    end
    checks++;
    if (q !== eq) begin
      errors++;
      $display("FAIL %s quotient: got %h want %h", nm, q, eq);
    end
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL %s remainder: got %h want %h", nm, r, er);
    end
    checks++;
    if (z !== ed) begin
      errors++;
      $display("FAIL %s dbz: got %b want %b", nm, z, ed);
    end
    @(negedge clk);
    bz = (sel == 1) ? busy1 : busy2;
    dn = (sel == 1) ? done1 : done2;
    checks++;
    if (bz !== 1'b0 || dn !== 1'b0) begin
      errors++;
      $display("FAIL %s idle after done: busy=%b done=%b want 0 0", nm, bz, dn);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || dbz1 !== 1'b0) begin
      errors++;
      $display("FAIL reset flags dut1: busy=%b done=%b dbz=%b want 0 0 0", busy1, done1, dbz1);
    end
    checks++;
    if (q1 !== 64'd0 || r1 !== 64'd0) begin
      errors++;
      $display("FAIL reset results dut1: q=%h r=%h want 0 0", q1, r1);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || dbz2 !== 1'b0) begin
      errors++;
      $display("FAIL reset flags dut2: busy=%b done=%b dbz=%b want 0 0 0", busy2, done2, dbz2);
    end
    checks++;
    if (q2 !== 64'd0 || r2 !== 64'd0) begin
      errors++;
      $display("FAIL reset results dut2: q=%h r=%h want 0 0", q2, r2);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    do_op(1, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, "u100/7");
    do_op(1, 1'b0, 64'd1000000007, 64'd12345, 64'd81004, 64'd5627, 1'b0, "u1e9/12345");
    do_op(1, 1'b0, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 1'b0, "uones/16");
  endtask

  task automatic test_signed();
    do_op(1, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, "s-7/2");
    do_op(1, 1'b1, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 1'b0, "s7/-2");
    do_op(1, 1'b1, -64'sd7, -64'sd2, 64'd3, ONES, 1'b0, "s-7/-2");
    do_op(1, 1'b1, -64'sd100, 64'd7, -64'sd14, -64'sd2, 1'b0, "s-100/7");
  endtask

  task automatic test_div_by_zero();
    do_op(1, 1'b0, 64'd5, 64'd0, ONES, 64'd5, 1'b1, "u5/0");
    do_op(1, 1'b1, 64'd5, 64'd0, ONES, 64'd5, 1'b1, "s5/0");
    do_op(1, 1'b1, -64'sd5, 64'd0, ONES, -64'sd5, 1'b1, "s-5/0");
  endtask

  task automatic test_overflow();
    do_op(1, 1'b1, MIN, ONES, MIN, 64'd0, 1'b0, "smin/-1");
    do_op(1, 1'b0, MIN, ONES, 64'd0, MIN, 1'b0, "umin/ones");
    do_op(1, 1'b1, MIN, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 1'b0, "smin/2");
  endtask

  // 100/7 started at cycle 0; init pulses at cycles 10 and 66 must be ignored.
  task automatic test_ignore_init();
    int bad_cyc;
    bad_cyc = -1;
    @(negedge clk);
    sgn = 1'b0; dvd = 64'd100; dvs = 64'd7; init1 = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      init1 = (c == 10 || c == 66);
      if (c == 10) begin dvd = 64'd9; dvs = 64'd3; end
      if ((busy1 !== (c <= 66) || done1 !== (c == 66)) && bad_cyc < 0) bad_cyc = c;
    end
    init1 = 1'b0;
    checks++;
    if (bad_cyc >= 0) begin
      errors++;
      $display("FAIL ignore_init timing: busy/done wrong at cycle %0d, done required only at 66", bad_cyc);
    end
    checks++;
    if (q1 !== 64'd14 || r1 !== 64'd2) begin
      errors++;
      $display("FAIL ignore_init result: q=%0d r=%0d want 14 2", q1, r1);
    end
  endtask

  // Reset at cycle 30 of an op aborts it; a fresh 9/3 then runs normally.
  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    @(negedge clk);
    sgn = 1'b0; dvd = 64'd100; dvs = 64'd7; init1 = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      init1 = 1'b0;
      rst = (c == 30);
      if (c == 31) begin
        checks++;
        if (busy1 !== 1'b0 || done1 !== 1'b0 || dbz1 !== 1'b0 || q1 !== 64'd0 || r1 !== 64'd0) begin
          errors++;
          $display("FAIL reset_mid outputs: busy=%b done=%b dbz=%b q=%h r=%h want all 0", busy1, done1, dbz1, q1, r1);
        end
      end
      if (done1 === 1'b1) done_seen++;
    end
    rst = 1'b0;
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL reset_mid done pulses: got %0d want 0", done_seen);
    end
    do_op(1, 1'b0, 64'd9, 64'd3, 64'd3, 64'd0, 1'b0, "u9/3 after reset");
  endtask

  task automatic test_two_bits();
    do_op(2, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, "w2 u100/7");
    do_op(2, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, ONES, 1'b0, "w2 s-7/2");
    do_op(2, 1'b1, MIN, ONES, MIN, 64'd0, 1'b0, "w2 smin/-1");
    do_op(2, 1'b1, MAX, ONES, 64'h8000_0000_0000_0001, 64'd0, 1'b0, "w2 smax/-1");
    do_op(2, 1'b0, ONES, 64'd1, ONES, 64'd0, 1'b0, "w2 uones/1");
    do_op(2, 1'b0, 64'd1, ONES, 64'd0, 64'd1, 1'b0, "w2 u1/ones");
    do_op(2, 1'b1, 64'd1, ONES, ONES, 64'd0, 1'b0, "w2 s1/-1");
    do_op(2, 1'b1, ONES, MIN, 64'd0, ONES, 1'b0, "w2 s-1/min");
    do_op(2, 1'b0, 64'd0, 64'd9, 64'd0, 64'd0, 1'b0, "w2 u0/9");
    do_op(2, 1'b1, -64'sd5, 64'd0, ONES, -64'sd5, 1'b1, "w2 s-5/0");
  endtask

  // dut2: op A at cycle 0 (done 34), op B at cycle 35 (done 69); A holds until B's done.
  task automatic test_back_to_back();
    int   bad_cyc;
    logic held_ok;
    bad_cyc = -1;
    held_ok = 1'b1;
    @(negedge clk);
    sgn = 1'b0; dvd = 64'd100; dvs = 64'd7; init2 = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      init2 = (c == 35);
      if (c == 35) begin sgn = 1'b1; dvd = 64'd7; dvs = -64'sd2; end
      if ((busy2 !== (c != 35 && c <= 69) || done2 !== (c == 34 || c == 69)) && bad_cyc < 0) bad_cyc = c;
      if (c >= 34 && c <= 68 && (q2 !== 64'd14 || r2 !== 64'd2)) held_ok = 1'b0;
      if (c == 69) begin
        checks++;
        if (q2 !== 64'hFFFF_FFFF_FFFF_FFFD || r2 !== 64'd1) begin
          errors++;
          $display("FAIL b2b second result: q=%h r=%h want fffffffffffffffd 1", q2, r2);
        end
      end
    end
    init2 = 1'b0;
    checks++;
    if (bad_cyc >= 0) begin
      errors++;
      $display("FAIL b2b timing: busy/done wrong at cycle %0d, done required at 34 and 69", bad_cyc);
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL b2b first result held: got q=%h r=%h want 14 2 through cycle 68", q2, r2);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_ignore_init();
    test_reset_mid();
    test_two_bits();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
